// File: rtl/inv_sub_bytes_unit.sv
// AES InvSubBytes stage: substitutes each byte of a NUM_BYTES-byte state through a registered
// inverse S-box ROM. Define INV_SUB_BYTES_2X_EN to use two ROMs and look up byte pairs per cycle.
module inv_sub_bytes_unit #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] state_out,
    output logic [1:0]             fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid, once raised, holds its payload stable until that edge.

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = $clog2(NUM_BYTES);
`ifdef INV_SUB_BYTES_2X_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int ISSUES = NUM_BYTES / LANES;
    localparam logic [IW-1:0] LAST_IDX = IW'(ISSUES - 1);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [W-1:0]       in_buf;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      wr_idx;
    logic               wr_pend;
    logic               drain;
    logic [8*LANES-1:0] rom_q;

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return INV_SBOX[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [7:0] get_byte(input logic [W-1:0] v, input int i);
        return v[8*(NUM_BYTES - i) - 1 -: 8];
    endfunction

    assign fsm_state = state;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                // drain is set once the last lookup is issued; this cycle writes it back
                if (drain) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            in_buf    <= '0;
            idx       <= '0;
            wr_idx    <= '0;
            wr_pend   <= 1'b0;
            drain     <= 1'b0;
            rom_q     <= '0;
            state_out <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                in_buf  <= state_in;
                idx     <= '0;
                drain   <= 1'b0;
                wr_pend <= 1'b0;
            end
            if (state == RUN) begin
                // ROM output from the previous cycle lands in its result bytes
                if (wr_pend) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (b == LANES*int'(wr_idx) + l)
                                state_out[8*(NUM_BYTES - b) - 1 -: 8] <= rom_q[8*(LANES - l) - 1 -: 8];
                        end
                    end
                end
                if (!drain) begin
                    for (int l = 0; l < LANES; l++)
                        rom_q[8*(LANES - l) - 1 -: 8] <= inv_sbox(get_byte(in_buf, LANES*int'(idx) + l));
                    wr_idx  <= idx;
                    wr_pend <= 1'b1;
                    if (idx == LAST_IDX) drain <= 1'b1;
                    else                 idx   <= idx + 1'b1;
                end else begin
                    wr_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_unit.sv
// Bench for inv_sub_bytes_unit: reference S-boxes derived from GF(2^8) inversion and the
// AES affine map, directed corner cases, then a randomized encrypt-S-box round trip.
module tb_inv_sub_bytes_unit;

    logic         CLK;
    logic         RST_N;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [1:0]   fsm_state;

`ifdef INV_SUB_BYTES_2X_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sub_bytes_unit #(.NUM_BYTES(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .fsm_state (fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) r = 8'(c);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
    endfunction

    function automatic logic [127:0] map_state(input logic [127:0] s, input bit inverse);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*(16 - i) - 1 -: 8] = inverse ? inv_tab[s[8*(16 - i) - 1 -: 8]]
                                             : fwd_tab[s[8*(16 - i) - 1 -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking and drivers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [127:0] din, input bit rnd, output int lat,
                             output logic [127:0] dout);
        int w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        state_in = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        state_in = rand128();
        lat = 0;
        do begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            lat++;
        end while (!out_valid && lat < 200);
        out_ready = 1'b0;
        dout = state_out;
    endtask

    task automatic finish_job(input logic [127:0] held, input bit rnd, input string tag);
        int  w    = 0;
        bit  done = 1'b0;
        logic r;
        while (!done && w < 100) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            tick();
            w++;
            if (r) begin
                chk({tag, " out_valid after handshake"}, 128'(out_valid), 128'(0));
                chk({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1));
                done = 1'b1;
            end else begin
                chk({tag, " state_out held"}, state_out, held);
            end
        end
        out_ready = 1'b0;
        chk({tag, " handshake completed"}, 128'(done), 128'(1));
    endtask

    task automatic full_job(input logic [127:0] din, input logic [127:0] exp, input string tag);
        int lat;
        logic [127:0] dout;
        start_job(din, 1'b0, lat, dout);
        chk({tag, " latency"}, 128'(lat), 128'(LAT));
        chk({tag, " result"}, dout, exp);
        finish_job(dout, 1'b0, tag);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int lat;
        logic [127:0] dout, orig;

        for (int i = 0; i < 256; i++) begin
            fwd_tab[i] = affine(ginv(8'(i)));
            inv_tab[i] = ginv(inv_affine(8'(i)));
        end

        RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset state_out", state_out, 128'h0);

        // known vector, then DONE hold with stray in_valid pulses
        start_job(128'h637C777BF26B6FC53001672BFED7AB76, 1'b0, lat, dout);
        chk("vec latency", 128'(lat), 128'(LAT));
        chk("vec result", dout, 128'h000102030405060708090A0B0C0D0E0F);
        chk("vec model", dout, map_state(128'h637C777BF26B6FC53001672BFED7AB76, 1'b1));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            state_in = rand128();
            tick();
            chk("hold out_valid", 128'(out_valid), 128'(1));
            chk("hold in_ready", 128'(in_ready), 128'(0));
            chk("hold state_out", state_out, 128'h000102030405060708090A0B0C0D0E0F);
        end
        in_valid = 1'b0;
        finish_job(dout, 1'b0, "vec");

        full_job({16{8'h63}}, {16{8'h00}}, "all63");
        full_job({16{8'h00}}, {16{8'h52}}, "all00");
        full_job({16{8'h16}}, {16{8'hFF}}, "all16");
        full_job({8'hED, {15{8'h63}}}, {8'h53, {15{8'h00}}}, "byteED");
        full_job({16{8'h16}}, {16{8'hFF}}, "all16b");

        // reset while RUN is at index 7
        orig = rand128();
        state_in = orig;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        tick();
        chk("midreset in_ready", 128'(in_ready), 128'(1));
        chk("midreset out_valid", 128'(out_valid), 128'(0));
        chk("midreset state_out", state_out, 128'h0);
        RST_N = 1'b1;
        full_job(orig, map_state(orig, 1'b1), "after reset");

        // random round trip with out_ready toggling
        for (int k = 0; k < 200; k++) begin
            orig = rand128();
            start_job(map_state(orig, 1'b0), 1'b1, lat, dout);
            chk("rt latency", 128'(lat), 128'(LAT));
            chk("rt result", dout, orig);
            finish_job(dout, 1'b1, "rt");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
